// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: arbiter FSM state encoding and counter widths
package axis_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;
  localparam int BEAT_CNT_W  = 8;
  localparam int PKT_CNT_W   = 16;
  localparam int TRUNC_CNT_W = 8;
  localparam logic [TRUNC_CNT_W-1:0] TRUNC_MAX = '1;
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: 2-entry skid register slice, 1-cycle latency; s_* in (s_ready registered), m_* out
module axis_reg_slice #(
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_data,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_strb,
  input  logic                            s_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_data,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_strb,
  output logic                            m_last
);
  localparam int PW = C_AXIS_TDATA_WIDTH + C_AXIS_TDATA_WIDTH / 8 + 1;
  logic [PW-1:0] out_q, out_d, skid_q, skid_d, s_pay;
  logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, in_fire, out_free;
  assign s_ready = !skid_vld_q;
  assign m_valid = out_vld_q;
  assign {m_data, m_strb, m_last} = out_q;
  always_comb begin
    s_pay      = {s_data, s_strb, s_last};
    in_fire    = s_valid && !skid_vld_q;
    out_free   = !out_vld_q || m_ready;
    out_vld_d  = out_free ? (skid_vld_q || in_fire) : out_vld_q;
    out_d      = !out_free ? out_q : skid_vld_q ? skid_q : in_fire ? s_pay : out_q;
    skid_vld_d = !out_free && (skid_vld_q || in_fire);
    skid_d     = (!out_free && in_fire) ? s_pay : skid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: 2-way round-robin AXIS packet arbiter; S0/S1 in, M out via skid slice, status grant_id/busy/pkt_cnt0/pkt_cnt1/trunc_cnt
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_MAX_BEATS        = 8
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESET,
  input  logic                            S0_AXIS_TVALID,
  output logic                            S0_AXIS_TREADY,
  input  logic                            S0_AXIS_TLAST,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S0_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S0_AXIS_TSTRB,
  input  logic                            S1_AXIS_TVALID,
  output logic                            S1_AXIS_TREADY,
  input  logic                            S1_AXIS_TLAST,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S1_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S1_AXIS_TSTRB,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                            grant_id,
  output logic                            busy,
  output logic [PKT_CNT_W-1:0]            pkt_cnt0,
  output logic [PKT_CNT_W-1:0]            pkt_cnt1,
  output logic [TRUNC_CNT_W-1:0]          trunc_cnt
);
  localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(C_MAX_BEATS - 1);
  arb_state_e state_q, state_d, idle_pick;
  logic last_grant_q, last_grant_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PKT_CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d, pkt_cnt1_q, pkt_cnt1_d;
  logic [TRUNC_CNT_W-1:0] trunc_cnt_q, trunc_cnt_d;
  logic sel, s_valid, s_last, fwd_valid, fwd_last, slice_ready, fire, pkt_end, forced;
  logic [C_AXIS_TDATA_WIDTH-1:0] s_data;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_strb;
  assign busy      = state_q != IDLE;
  assign grant_id  = state_q == GRANT1;
  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;
  assign trunc_cnt = trunc_cnt_q;
  // Gated by reset so a source never sees a handshake the slice is about to discard.
  assign S0_AXIS_TREADY = !AXIS_ARESET && state_q == GRANT0 && slice_ready;
  assign S1_AXIS_TREADY = !AXIS_ARESET && state_q == GRANT1 && slice_ready;
  always_comb begin
    sel       = state_q == GRANT1;
    s_valid   = sel ? S1_AXIS_TVALID : S0_AXIS_TVALID;
    s_last    = sel ? S1_AXIS_TLAST : S0_AXIS_TLAST;
    s_data    = sel ? S1_AXIS_TDATA : S0_AXIS_TDATA;
    s_strb    = sel ? S1_AXIS_TSTRB : S0_AXIS_TSTRB;
    fwd_valid = busy && s_valid;
    fwd_last  = s_last || beat_cnt_q == BEAT_LAST;
    fire      = fwd_valid && slice_ready;
    pkt_end   = fire && fwd_last;
    forced    = pkt_end && !s_last;
    idle_pick = (S0_AXIS_TVALID && S1_AXIS_TVALID) ? (last_grant_q ? GRANT0 : GRANT1) :
                S0_AXIS_TVALID ? GRANT0 : S1_AXIS_TVALID ? GRANT1 : IDLE;
    state_d      = !busy ? idle_pick : pkt_end ? IDLE : state_q;
    last_grant_d = pkt_end ? sel : last_grant_q;
    beat_cnt_d   = pkt_end ? '0 : fire ? beat_cnt_q + BEAT_CNT_W'(1) : beat_cnt_q;
    pkt_cnt0_d   = (pkt_end && !sel) ? pkt_cnt0_q + PKT_CNT_W'(1) : pkt_cnt0_q;
    pkt_cnt1_d   = (pkt_end && sel) ? pkt_cnt1_q + PKT_CNT_W'(1) : pkt_cnt1_q;
    trunc_cnt_d  = (forced && trunc_cnt_q != TRUNC_MAX) ? trunc_cnt_q + TRUNC_CNT_W'(1) : trunc_cnt_q;
  end
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      trunc_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
      trunc_cnt_q  <= trunc_cnt_d;
    end
  end
  axis_reg_slice #(.C_AXIS_TDATA_WIDTH(C_AXIS_TDATA_WIDTH)) u_slice (
    .clk     (AXIS_ACLK),
    .rst     (AXIS_ARESET),
    .s_valid (fwd_valid),
    .s_ready (slice_ready),
    .s_data  (s_data),
    .s_strb  (s_strb),
    .s_last  (fwd_last),
    .m_valid (M_AXIS_TVALID),
    .m_ready (M_AXIS_TREADY),
    .m_data  (M_AXIS_TDATA),
    .m_strb  (M_AXIS_TSTRB),
    .m_last  (M_AXIS_TLAST)
  );
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed self-checking bench for axis_rr_arbiter
module tb_axis_rr_arbiter;
  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} beat_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic s0_v, s0_r, s0_l, s1_v, s1_r, s1_l, m_v, m_l, grant_id, busy;
  logic m_r = 1'b1;
  logic [31:0] s0_d, s1_d, m_d;
  logic [3:0] s0_s, s1_s, m_s;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic [7:0] trunc_cnt;
  beat_t q0[$], q1[$], outq[$];
  int out_cyc[$], in0_cyc[$], grant_q[$];
  logic busy_q[$];
  bit en0 = 1, en1 = 1;
  int in0_n = 0, in1_n = 0, cyc = 0, vectors = 0, errors = 0;
  logic busy_prev = 1'b0;

  axis_rr_arbiter #(.C_AXIS_TDATA_WIDTH(32), .C_MAX_BEATS(8)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S0_AXIS_TVALID(s0_v), .S0_AXIS_TREADY(s0_r), .S0_AXIS_TLAST(s0_l),
    .S0_AXIS_TDATA(s0_d), .S0_AXIS_TSTRB(s0_s),
    .S1_AXIS_TVALID(s1_v), .S1_AXIS_TREADY(s1_r), .S1_AXIS_TLAST(s1_l),
    .S1_AXIS_TDATA(s1_d), .S1_AXIS_TSTRB(s1_s),
    .M_AXIS_TVALID(m_v), .M_AXIS_TREADY(m_r), .M_AXIS_TLAST(m_l),
    .M_AXIS_TDATA(m_d), .M_AXIS_TSTRB(m_s),
    .grant_id(grant_id), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
    .trunc_cnt(trunc_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bit f;
    s0_v = 0; s0_d = 0; s0_s = 0; s0_l = 0;
    forever begin
      @(negedge clk);
      f = s0_v && s0_r;
      if (f) in0_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      if (f && q0.size() > 0) begin
        void'(q0.pop_front());
        in0_n++;
      end
      s0_v = en0 && q0.size() > 0;
      if (q0.size() > 0) {s0_d, s0_s, s0_l} = q0[0];
    end
  end

  initial begin
    bit f;
    s1_v = 0; s1_d = 0; s1_s = 0; s1_l = 0;
    forever begin
      @(negedge clk);
      f = s1_v && s1_r;
      @(posedge clk);
      #1;
      if (f && q1.size() > 0) begin
        void'(q1.pop_front());
        in1_n++;
      end
      s1_v = en1 && q1.size() > 0;
      if (q1.size() > 0) {s1_d, s1_s, s1_l} = q1[0];
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_v && m_r) begin
      outq.push_back({m_d, m_s, m_l});
      out_cyc.push_back(cyc);
    end
    if (busy && !busy_prev) grant_q.push_back(int'(grant_id));
    busy_prev = busy;
    busy_q.push_back(busy);
  end

  task start_reset();
    rst = 1; m_r = 1; en0 = 1; en1 = 1;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #2;
  endtask

  task release_reset();
    @(posedge clk);
    #1;
    rst = 0;
    outq.delete(); out_cyc.delete(); in0_cyc.delete(); grant_q.delete(); busy_q.delete();
    in0_n = 0; in1_n = 0;
  endtask

  task wait_out(input int n);
    for (int i = 0; i < 300 && outq.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task test_reset();
    start_reset();
    @(negedge clk);
    vectors++;
    if ({busy, grant_id, m_v, m_l, s0_r, s1_r} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/gid/mv/ml/r0/r1 got %b want 000000", {busy, grant_id, m_v, m_l, s0_r, s1_r});
    end
    vectors++;
    if ({m_d, m_s} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 0/0", m_d, m_s);
    end
    vectors++;
    if ({pkt_cnt0, pkt_cnt1, trunc_cnt} !== 40'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", pkt_cnt0, pkt_cnt1, trunc_cnt);
    end
  endtask

  task test_single();
    beat_t exp, got;
    start_reset();
    for (int i = 0; i < 4; i++) q0.push_back({32'h11 + 32'(i), 4'(i + 1), i == 3});
    release_reset();
    wait_out(4);
    vectors++;
    if (outq.size() != 4) begin
      errors++;
      $display("FAIL single_count: got %0d want 4", outq.size());
    end
    for (int i = 0; i < 4; i++) begin
      exp = {32'h11 + 32'(i), 4'(i + 1), i == 3};
      got = (i < outq.size()) ? outq[i] : 'x;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_beat%0d: got %h/%h/%b want %h/%h/%b", i, got.d, got.s, got.l, exp.d, exp.s, exp.l);
      end
      vectors++;
      if (i >= out_cyc.size() || i >= in0_cyc.size() || out_cyc[i] !== in0_cyc[i] + 1) begin
        errors++;
        $display("FAIL single_latency%0d: output cycle not input cycle + 1", i);
      end
    end
    vectors++;
    if ({pkt_cnt0, pkt_cnt1, trunc_cnt, busy} !== {16'd1, 16'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_cnt: got %0d/%0d/%0d busy %b want 1/0/0 busy 0", pkt_cnt0, pkt_cnt1, trunc_cnt, busy);
    end
  endtask

  task test_tie();
    logic [31:0] exp_d [8] = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hA2, 32'hA3, 32'hB2, 32'hB3};
    int exp_g [4] = '{0, 1, 0, 1};
    logic [11:0] trace;
    beat_t got;
    start_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({32'hA0 + 32'(i), 4'hF, i % 2 == 1});
      q1.push_back({32'hB0 + 32'(i), 4'hF, i % 2 == 1});
    end
    release_reset();
    wait_out(8);
    for (int i = 0; i < 8; i++) begin
      got = (i < outq.size()) ? outq[i] : 'x;
      vectors++;
      if ({got.d, got.l} !== {exp_d[i], i % 2 == 1}) begin
        errors++;
        $display("FAIL tie_beat%0d: got %h/%b want %h/%b", i, got.d, got.l, exp_d[i], i % 2 == 1);
      end
    end
    vectors++;
    if (grant_q.size() != 4) begin
      errors++;
      $display("FAIL tie_grants: got %0d grants want 4", grant_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (grant_q[i] !== exp_g[i]) begin
          errors++;
          $display("FAIL tie_grant%0d: got %0d want %0d", i, grant_q[i], exp_g[i]);
        end
      end
    end
    trace = 'x;
    for (int i = 0; i < 12 && i < busy_q.size(); i++) trace[11-i] = busy_q[i];
    vectors++;
    if (trace !== 12'b011011011011) begin
      errors++;
      $display("FAIL tie_busy_trace: got %b want 011011011011", trace);
    end
    vectors++;
    if ({pkt_cnt0, pkt_cnt1} !== {16'd2, 16'd2}) begin
      errors++;
      $display("FAIL tie_cnt: got %0d/%0d want 2/2", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task test_trunc();
    beat_t got;
    start_reset();
    for (int i = 0; i < 10; i++) q1.push_back({32'h21 + 32'(i), 4'hF, i == 9});
    release_reset();
    wait_out(10);
    vectors++;
    if (outq.size() != 10) begin
      errors++;
      $display("FAIL trunc_count: got %0d want 10", outq.size());
    end
    for (int i = 0; i < 10; i++) begin
      got = (i < outq.size()) ? outq[i] : 'x;
      vectors++;
      if ({got.d, got.l} !== {32'h21 + 32'(i), i == 7 || i == 9}) begin
        errors++;
        $display("FAIL trunc_beat%0d: got %h/%b want %h/%b", i, got.d, got.l, 32'h21 + 32'(i), i == 7 || i == 9);
      end
    end
    vectors++;
    if ({trunc_cnt, pkt_cnt1, pkt_cnt0} !== {8'd1, 16'd2, 16'd0}) begin
      errors++;
      $display("FAIL trunc_cnt: trunc/p1/p0 got %0d/%0d/%0d want 1/2/0", trunc_cnt, pkt_cnt1, pkt_cnt0);
    end
    vectors++;
    if (grant_q.size() != 2 || grant_q[0] !== 1 || grant_q[1] !== 1) begin
      errors++;
      $display("FAIL trunc_grants: got %0d grants want two grants to 1", grant_q.size());
    end
  endtask

  task test_backpressure();
    bit pat [4] = '{1, 0, 0, 1};
    bit stalled;
    beat_t held, got;
    start_reset();
    for (int i = 0; i < 8; i++) q0.push_back({32'h31 + 32'(i), 4'hF, i == 7});
    release_reset();
    stalled = 0;
    held = '0;
    for (int c = 0; c < 200 && outq.size() < 8; c++) begin
      @(posedge clk);
      #1;
      m_r = pat[c % 4];
      @(negedge clk);
      if (stalled) begin
        vectors++;
        if (!m_v || {m_d, m_s, m_l} !== held) begin
          errors++;
          $display("FAIL bp_hold: got v=%b %h want v=1 %h", m_v, m_d, held.d);
        end
      end
      stalled = m_v && !m_r;
      held = {m_d, m_s, m_l};
    end
    m_r = 1;
    wait_out(8);
    vectors++;
    if (outq.size() != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d want 8", outq.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < outq.size()) ? outq[i] : 'x;
      vectors++;
      if (got !== {32'h31 + 32'(i), 4'hF, i == 7}) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, got.d, got.l, 32'h31 + 32'(i), i == 7);
      end
    end
    vectors++;
    if (pkt_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL bp_cnt: got %0d want 1", pkt_cnt0);
    end
  endtask

  task test_mid_reset();
    start_reset();
    q0.push_back({32'h40, 4'hF, 1'b1});
    for (int i = 0; i < 8; i++) q0.push_back({32'h41 + 32'(i), 4'hF, i == 7});
    release_reset();
    for (int c = 0; c < 100 && in0_n < 3; c++) @(negedge clk);
    vectors++;
    if (pkt_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL mid_pre_cnt: got %0d want 1", pkt_cnt0);
    end
    q0.delete();
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    outq.delete(); grant_q.delete();
    @(negedge clk);
    vectors++;
    if ({m_v, m_l, busy, grant_id, s0_r, s1_r, m_d, m_s} !== 42'h0) begin
      errors++;
      $display("FAIL mid_outputs: v/l/busy/gid %b%b%b%b data %h strb %h want all 0", m_v, m_l, busy, grant_id, m_d, m_s);
    end
    vectors++;
    if ({pkt_cnt0, pkt_cnt1, trunc_cnt} !== 40'h0) begin
      errors++;
      $display("FAIL mid_cnt: got %0d/%0d/%0d want 0/0/0", pkt_cnt0, pkt_cnt1, trunc_cnt);
    end
    q0.push_back({32'h51, 4'hF, 1'b1});
    q1.push_back({32'h61, 4'hF, 1'b1});
    wait_out(2);
    vectors++;
    if (outq.size() != 2 || outq[0].d !== 32'h51 || outq[1].d !== 32'h61) begin
      errors++;
      $display("FAIL mid_after: got %0d beats first %h want 2 beats 51,61", outq.size(), outq.size() > 0 ? outq[0].d : 32'hx);
    end
    vectors++;
    if (grant_q.size() != 2 || grant_q[0] !== 0 || grant_q[1] !== 1) begin
      errors++;
      $display("FAIL mid_grants: got %0d grants first %0d want 0,1", grant_q.size(), grant_q.size() > 0 ? grant_q[0] : -1);
    end
  endtask

  task test_stall_hold();
    beat_t got;
    start_reset();
    for (int i = 0; i < 6; i++) q0.push_back({32'h71 + 32'(i), 4'hF, i == 5});
    q1.push_back({32'h81, 4'hF, 1'b1});
    release_reset();
    for (int c = 0; c < 100 && in0_n < 2; c++) @(negedge clk);
    en0 = 0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, grant_id, s1_r, s0_v} !== 4'b1000) begin
        errors++;
        $display("FAIL stall_hold%0d: busy/gid/s1_ready/s0_valid got %b want 1000", c, {busy, grant_id, s1_r, s0_v});
      end
    end
    en0 = 1;
    wait_out(7);
    vectors++;
    if (outq.size() != 7) begin
      errors++;
      $display("FAIL stall_count: got %0d want 7", outq.size());
    end
    for (int i = 0; i < 7; i++) begin
      got = (i < outq.size()) ? outq[i] : 'x;
      vectors++;
      if (got.d !== (i < 6 ? 32'h71 + 32'(i) : 32'h81)) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h want %h", i, got.d, i < 6 ? 32'h71 + 32'(i) : 32'h81);
      end
    end
    vectors++;
    if ({pkt_cnt0, pkt_cnt1} !== {16'd1, 16'd1} || grant_q.size() != 2 || grant_q[0] !== 0) begin
      errors++;
      $display("FAIL stall_cnt: got %0d/%0d grants %0d want 1/1 grants 2 starting at 0", pkt_cnt0, pkt_cnt1, grant_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_trunc();
    test_backpressure();
    test_mid_reset();
    test_stall_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
